// File: rtl/strobe_fifo_pkg.sv
// Shared constants and helpers for the strobe-to-stream buffer.
// Drop counter width and its saturating increment live here.
package strobe_fifo_pkg;

    localparam int DROP_W = 8;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    function automatic logic [DROP_W-1:0] sat_inc(
        input logic [DROP_W-1:0] v
    );
        return (v == DROP_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/strobe_fifo_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read.
// Left unreset so it can map onto distributed RAM.
module fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/strobe_fifo.sv
// Buffers single-cycle strobes into a first-word-fall-through valid/ready
// stream, counting strobes lost while full.
module strobe_fifo
    import strobe_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     strobe_in,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count
);

    localparam int AW = $clog2(DEPTH);

    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
        $error("strobe_fifo: DEPTH must be a power of two >= 2");
    end

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] rdata;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                 && (wr_ptr[AW] != rd_ptr[AW]);

    assign out_valid = !empty;
    assign pop  = out_valid & out_ready;
    // A pop on the same edge frees the slot, so a full buffer still accepts.
    assign push = strobe_in & (!full | pop);
    assign drop = strobe_in & full & !pop;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data_in),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    assign out_data = empty ? '0 : rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                level <= level + 1'b1;
            end else if (pop && !push) begin
                level <= level - 1'b1;
            end
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
        end
    end

endmodule

// File: tb/tb_strobe_fifo.sv
// Directed bench for strobe_fifo: vector table plus multi-cycle sequences.
// Expected values are hand-derived for WIDTH=8, DEPTH=4.
module tb_strobe_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             strobe_in;
    logic [WIDTH-1:0] data_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       level;
    logic             overflow;
    logic [7:0]       drop_count;

    int checks = 0;
    int errors = 0;

    strobe_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .strobe_in  (strobe_in),
        .data_in    (data_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       s;
        logic [7:0] d;
        logic       r;
        logic       ev;
        logic [7:0] ed;
        int         el;
        logic       eo;
        int         ec;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev,
                           input int ed, input int el,
                           input logic eo, input int ec);
        chk({tag, " out_valid"}, int'(out_valid), int'(ev));
        chk({tag, " out_data"}, int'(out_data), ed);
        chk({tag, " level"}, int'(level), el);
        chk({tag, " overflow"}, int'(overflow), int'(eo));
        chk({tag, " drop_count"}, int'(drop_count), ec);
    endtask

    task automatic step(input logic s, input logic [7:0] d, input logic r);
        @(negedge clk);
        strobe_in = s;
        data_in   = d;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        strobe_in = 1'b0;
        data_in   = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1, 1'b0, 0};
        vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 0};
        vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 0};
        vecs[3]  = '{1'b1, 8'd1,  1'b0, 1'b1, 8'd1,  1, 1'b0, 0};
        vecs[4]  = '{1'b1, 8'd2,  1'b0, 1'b1, 8'd1,  2, 1'b0, 0};
        vecs[5]  = '{1'b1, 8'd3,  1'b0, 1'b1, 8'd1,  3, 1'b0, 0};
        vecs[6]  = '{1'b1, 8'd4,  1'b0, 1'b1, 8'd1,  4, 1'b0, 0};
        vecs[7]  = '{1'b1, 8'd5,  1'b0, 1'b1, 8'd1,  4, 1'b1, 1};
        vecs[8]  = '{1'b1, 8'd6,  1'b0, 1'b1, 8'd1,  4, 1'b1, 2};
        vecs[9]  = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd2,  3, 1'b1, 2};
        vecs[10] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd3,  2, 1'b1, 2};
        vecs[11] = '{1'b0, 8'd0,  1'b1, 1'b1, 8'd4,  1, 1'b1, 2};
        vecs[12] = '{1'b0, 8'd0,  1'b1, 1'b0, 8'd0,  0, 1'b1, 2};

        reset = 1'b1;
        strobe_in = 1'b0;
        data_in = '0;
        out_ready = 1'b0;
        #12;
        chk_all("reset", 1'b0, 0, 0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single word, empty-ready no-op, fill/overflow, drain.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].s, vecs[i].d, vecs[i].r);
            chk_all($sformatf("vec%0d", i), vecs[i].ev, int'(vecs[i].ed),
                    vecs[i].el, vecs[i].eo, vecs[i].ec);
        end

        // Full with simultaneous pop: write accepted, no drop.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        chk("fullpop pre level", int'(level), 4);
        step(1'b1, 8'd5, 1'b1);
        chk_all("fullpop", 1'b1, 2, 4, 1'b0, 0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("fullpop drain%0d", i), int'(out_data), i);
            step(1'b0, 8'd0, 1'b1);
        end
        chk_all("fullpop empty", 1'b0, 0, 0, 1'b0, 0);

        // Wrap-around at one word per cycle.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(i), 1'b1);
            chk($sformatf("wrap data%0d", i), int'(out_data), i);
            chk($sformatf("wrap valid%0d", i), int'(out_valid), 1);
            chk($sformatf("wrap level%0d", i), int'(level), 1);
        end
        step(1'b0, 8'd0, 1'b1);
        chk_all("wrap end", 1'b0, 0, 0, 1'b0, 0);

        // Drop counter saturation.
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 8'hEE, 1'b0);
            if (i == 254) chk("sat at255", int'(drop_count), 255);
        end
        chk_all("sat", 1'b1, 1, 4, 1'b1, 255);

        // Asynchronous reset mid-operation.
        do_reset();
        for (int i = 1; i <= 5; i++) step(1'b1, 8'(i + 16), 1'b0);
        step(1'b0, 8'd0, 1'b1);
        chk_all("prereset", 1'b1, 18, 3, 1'b1, 1);
        @(negedge clk);
        out_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_all("async reset", 1'b0, 0, 0, 1'b0, 0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 8'h3C, 1'b0);
        chk_all("post reset", 1'b1, 8'h3C, 1, 1'b0, 0);
        step(1'b0, 8'd0, 1'b1);
        chk_all("post reset pop", 1'b0, 0, 0, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
